// File: rtl/ans_encoder.sv
// rANS encoder: renormalises, divides and updates the state per symbol, then
// flushes the final state MSB-first. The host reverses the nibble stream for the decoder.
module ans_encoder #(
   parameter int SYM_WIDTH   = 4,
   parameter int CNT_WIDTH   = 4,
   parameter int SYM_COUNT   = 16,
   parameter int STATE_WIDTH = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   en,
   input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
   input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
   input  logic [SYM_WIDTH-1:0]                   in,
   input  logic                                   in_last,
   input  logic                                   in_vld,
   output logic                                   in_rdy,
   output logic [SYM_WIDTH-1:0]                   out,
   output logic                                   out_vld,
   input  logic                                   out_rdy,
   output logic                                   done,
   output logic                                   err
);

   localparam int CUM_W = CNT_WIDTH + SYM_WIDTH;
   localparam int NIBS  = STATE_WIDTH / SYM_WIDTH;
   localparam int DCW   = $clog2(STATE_WIDTH);
   localparam int NCW   = (NIBS > 1) ? $clog2(NIBS) : 1;

   typedef enum logic [2:0] {IDLE, RENORM, DIVIDE, UPDATE, FLUSH} state_t;

   state_t                 state, state_d;
   logic [STATE_WIDTH-1:0] x, quo;
   logic [CNT_WIDTH-1:0]   rem, f_q, f_in;
   logic [CUM_W-1:0]       start_q, c_in, m;
   logic                   last_q, fresh;
   logic [DCW-1:0]         div_cnt;
   logic [NCW-1:0]         nib_cnt;
   logic                   need, in_xfer, out_xfer, nib_last, div_last;
   logic [CNT_WIDTH:0]     rem_sh;
   logic                   div_ge;

   assign f_in     = counts_unpacked[int'(in)*CNT_WIDTH +: CNT_WIDTH];
   assign c_in     = cumulative_unpacked[int'(in)*CUM_W +: CUM_W];
   assign m        = cumulative_unpacked[(SYM_COUNT-1)*CUM_W +: CUM_W];
   assign need     = x >= (STATE_WIDTH'(f_q) << SYM_WIDTH);
   assign div_last = div_cnt == DCW'(STATE_WIDTH-1);
   assign nib_last = nib_cnt == NCW'(NIBS-1);
   assign in_xfer  = en & in_vld & in_rdy;
   assign out_xfer = en & out_vld & out_rdy;

   // One restoring-division step: shift the next dividend bit into the remainder.
   always_comb begin
      rem_sh = {rem, quo[STATE_WIDTH-1]};
      div_ge = rem_sh >= {1'b0, f_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  state <= IDLE;
      else if (en) state <= state_d;
   end

   always_comb begin
      state_d = state;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      out     = '0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_vld) begin
               if (f_in == '0) state_d = in_last ? FLUSH : IDLE;
               else            state_d = RENORM;
            end
         end
         RENORM: begin
            if (need) begin
               out_vld = 1'b1;
               out     = x[SYM_WIDTH-1:0];
            end else begin
               state_d = DIVIDE;
            end
         end
         DIVIDE: if (div_last) state_d = UPDATE;
         UPDATE: state_d = last_q ? FLUSH : IDLE;
         FLUSH: begin
            out_vld = 1'b1;
            out     = x[STATE_WIDTH-1 -: SYM_WIDTH];
            if (out_rdy && nib_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x       <= '0;
         quo     <= '0;
         rem     <= '0;
         f_q     <= '0;
         start_q <= '0;
         last_q  <= 1'b0;
         fresh   <= 1'b1;
         div_cnt <= '0;
         nib_cnt <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else if (en) begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: if (in_xfer) begin
               f_q     <= f_in;
               start_q <= c_in - CUM_W'(f_in);
               last_q  <= in_last;
               err     <= (f_in == '0);
               if (fresh) begin
                  x     <= STATE_WIDTH'(m);
                  fresh <= 1'b0;
               end
            end
            RENORM: begin
               if (out_xfer) x <= x >> SYM_WIDTH;
               else if (!need) begin
                  quo     <= x;
                  rem     <= '0;
                  div_cnt <= '0;
               end
            end
            DIVIDE: begin
               quo     <= {quo[STATE_WIDTH-2:0], div_ge};
               rem     <= div_ge ? CNT_WIDTH'(rem_sh - {1'b0, f_q}) : rem_sh[CNT_WIDTH-1:0];
               div_cnt <= div_cnt + 1'b1;
            end
            UPDATE: x <= quo * STATE_WIDTH'(m) + STATE_WIDTH'(rem) + STATE_WIDTH'(start_q);
            FLUSH: if (out_xfer) begin
               // The flush shifts x left; the final nibble re-arms x=M for the next frame.
               if (nib_last) begin
                  x       <= STATE_WIDTH'(m);
                  nib_cnt <= '0;
                  done    <= 1'b1;
                  fresh   <= 1'b1;
               end else begin
                  x       <= x << SYM_WIDTH;
                  nib_cnt <= nib_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ans_encoder.sv
// Self-checking bench for ans_encoder: table-driven example frame, corner sequences,
// and randomized frames against an arithmetic rANS reference model.
module tb_ans_encoder;

   localparam int SW = 4, CW = 4, SC = 16, XW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n, en;
   logic [CW*SC-1:0]       counts;
   logic [(CW+SW)*SC-1:0]  cum;
   logic [SW-1:0]          in_sym, out;
   logic                   in_last, in_vld, in_rdy, out_vld, out_rdy, done, err;

   ans_encoder #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .SYM_COUNT(SC), .STATE_WIDTH(XW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .counts_unpacked(counts), .cumulative_unpacked(cum),
      .in(in_sym), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
      .out(out), .out_vld(out_vld), .out_rdy(out_rdy),
      .done(done), .err(err)
   );

   typedef struct {
      int          sym;
      bit          last;
      int          n_nib;
      logic [31:0] nibs;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   int         checks = 0, errors = 0;
   int         f_tab[SC];
   logic [3:0] got[$];
   int         exp_q[$];
   int         err_seen, done_seen, exp_err, lat;
   vec_t       vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_tables();
      int acc;
      acc = 0;
      for (int s = 0; s < SC; s++) begin
         acc += f_tab[s];
         counts[s*CW +: CW]        = f_tab[s][CW-1:0];
         cum[s*(CW+SW) +: (CW+SW)] = acc[CW+SW-1:0];
      end
   endtask

   // Reference rANS: x starts at M; renorm while x >= f*16; x = (x/f)*M + x%f + start.
   task automatic model_encode(input int syms[$]);
      int m, f, st;
      longint x;
      exp_q.delete();
      exp_err = 0;
      m = 0;
      for (int s = 0; s < SC; s++) m += f_tab[s];
      x = m;
      foreach (syms[i]) begin
         f  = f_tab[syms[i]];
         st = 0;
         for (int s = 0; s < syms[i]; s++) st += f_tab[s];
         if (f == 0) begin
            exp_err++;
            continue;
         end
         while (x >= f * 16) begin
            exp_q.push_back(int'(x % 16));
            x = x / 16;
         end
         x = (x / f) * m + x % f + st;
      end
      for (int k = XW/SW - 1; k >= 0; k--) exp_q.push_back(int'((x >> (4*k)) % 16));
   endtask

   // Entered and left at a negedge. lat = clock edges after the accept edge until
   // in_rdy (or done, for the last symbol) is seen.
   task automatic apply_sym(input int sym, input bit last, input int stall,
                            input logic [3:0] stall_nib, input bit rnd, input int en_at);
      int n, stalled;
      bit fin;
      n = 0;
      while (!in_rdy && n < 100) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!in_rdy) begin
         check("wait_in_rdy_timeout", 32'(in_rdy), 32'd1);
         return;
      end
      in_sym  = sym[SW-1:0];
      in_last = last;
      in_vld  = 1'b1;
      @(posedge clk);
      n = 0; fin = 0; stalled = 0;
      while (!fin && n < 400) begin
         @(negedge clk);
         in_vld = 1'b0;
         en     = !(en_at >= 0 && n >= en_at && n < en_at + 3);
         if (err)  err_seen++;
         if (done) done_seen++;
         if (last ? done : in_rdy) fin = 1;
         else begin
            if (out_vld && stalled < stall) begin
               check($sformatf("stall_hold_%0d", stalled), {out_vld, in_rdy, out}, {1'b1, 1'b0, stall_nib});
               out_rdy = 1'b0;
               stalled++;
            end else begin
               out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_vld && out_rdy && en) got.push_back(out);
            @(posedge clk);
            n++;
         end
      end
      en  = 1'b1;
      lat = n;
      if (!fin) check("symbol_timeout", 32'(fin), 32'd1);
   endtask

   task automatic run_frame(input int syms[$], input int stall_idx, input logic [3:0] stall_nib,
                            input bit rnd, input string tag);
      model_encode(syms);
      got.delete();
      err_seen = 0;
      done_seen = 0;
      foreach (syms[i])
         apply_sym(syms[i], i == syms.size() - 1, (i == stall_idx) ? 5 : 0, stall_nib, rnd, -1);
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check($sformatf("%s_nib%0d", tag, i), 32'(got[i]), exp_q[i]);
      check({tag, "_err"}, err_seen, exp_err);
      check({tag, "_done"}, done_seen, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base, len;
      int ex[$];
      int rq[$];

      vecs[0] = '{1, 1'b0, 0, 32'h0,       1'b0, 18};
      vecs[1] = '{0, 1'b0, 0, 32'h0,       1'b0, 18};
      vecs[2] = '{5, 1'b0, 0, 32'h0,       1'b1, 0};
      vecs[3] = '{1, 1'b0, 0, 32'h0,       1'b0, 18};
      vecs[4] = '{1, 1'b1, 5, 32'h000A1008, 1'b0, 23};
      ex = '{1, 0, 1, 1};

      foreach (f_tab[s]) f_tab[s] = 0;
      f_tab[0] = 8;
      f_tab[1] = 8;
      load_tables();
      rst_n = 1'b0; en = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_sym = '0; out_rdy = 1'b0;
      #12;
      check("reset_state", {in_rdy, out_vld, out, done, err}, {1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;

      // Example frame with a zero-count symbol spliced in: stream and x trace unchanged.
      got.delete();
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         base = got.size();
         err_seen = 0;
         apply_sym(vecs[i].sym, vecs[i].last, 0, 4'h0, 1'b0, -1);
         check($sformatf("vec%0d_nibcount", i), got.size() - base, vecs[i].n_nib);
         for (int k = 0; k < vecs[i].n_nib && base + k < got.size(); k++)
            check($sformatf("vec%0d_nib%0d", i, k), 32'(got[base+k]), 32'(vecs[i].nibs[k*4 +: 4]));
         check($sformatf("vec%0d_err", i), err_seen, 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      end
      check("vec_done_once", done_seen, 1);

      // Backpressure on the renorm nibble 8.
      run_frame(ex, 3, 4'h8, 1'b0, "backpressure");

      // Latency from x=M, plain and with en low for three cycles mid-divide.
      got.delete();
      apply_sym(1, 1'b0, 0, 4'h0, 1'b0, -1);
      check("latency_plain", lat, 18);
      apply_sym(0, 1'b1, 0, 4'h0, 1'b0, -1);
      apply_sym(1, 1'b0, 0, 4'h0, 1'b0, 5);
      check("latency_en_low", lat, 21);
      apply_sym(0, 1'b1, 0, 4'h0, 1'b0, -1);

      // Asynchronous reset in the middle of a divide.
      apply_sym(1, 1'b0, 0, 4'h0, 1'b0, -1);
      in_sym = 4'h1; in_last = 1'b0; in_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_before_reset", 32'(in_rdy), 32'd0);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {in_rdy, out_vld}, {1'b1, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(ex, -1, 4'h0, 1'b0, "after_reset");

      // Randomized tables, frames and output backpressure.
      for (int fr = 0; fr < 20; fr++) begin
         foreach (f_tab[s]) f_tab[s] = $urandom_range(0, 15);
         f_tab[$urandom_range(0, SC-1)] = $urandom_range(1, 15);
         load_tables();
         rq.delete();
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) rq.push_back($urandom_range(0, SC-1));
         run_frame(rq, -1, 4'h0, 1'b1, $sformatf("rand%0d", fr));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ans_encoder.md
Name: ans_encoder

Overview:
- rANS encoder that is the direct upstream producer for ans_decoder.
- Accepts a stream of symbols and encodes them against the shared counts/cumulative frequency tables.
- Emits a SYM_WIDTH-bit nibble stream made of renormalisation nibbles, followed by the final state flush.
- The host reverses the complete nibble stream before feeding ans_decoder. Symbols then decode in reverse (LIFO) order.

Parameters:
- SYM_WIDTH, 4: symbol width and output nibble width.
- CNT_WIDTH, 4: width of each count entry.
- SYM_COUNT, 16: number of table entries.
- STATE_WIDTH, 16: encoder state width. Must be >= CNT_WIDTH+2*SYM_WIDTH and a multiple of SYM_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; when low, all state and outputs freeze.
- counts_unpacked  in  CNT_WIDTH*SYM_COUNT  per-symbol count f[s]; entry s at bits [s*CNT_WIDTH +: CNT_WIDTH].
- cumulative_unpacked  in  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  inclusive cumulative C[s] = f[0]+..+f[s].
- in  in  SYM_WIDTH  symbol.
- in_last  in  1  qualifies the accepted symbol as the last one; a flush follows it.
- in_vld  in  1  symbol valid.
- in_rdy  out  1  symbol ready.
- out  out  SYM_WIDTH  output nibble.
- out_vld  out  1  nibble valid.
- out_rdy  in  1  nibble ready.
- done  out  1  one-cycle pulse after the last flush nibble transfers.
- err  out  1  one-cycle pulse when a symbol with f[s]==0 is accepted.

Behaviour:
- Reset (async, also mid-operation):
  - state IDLE, x = 0 (loaded to M on first symbol), in_rdy=1.
  - out_vld=0, out=0, done=0, err=0.
  - divider cleared; any frame in progress is abandoned and no further nibbles are emitted.
- Terms:
  - M = C[SYM_COUNT-1], sampled combinationally.
  - start[s] = C[s]-f[s].
  - Tables must be stable from the first accept until done.
- Handshakes: a transfer occurs on a clock edge where vld&&rdy. in_rdy is high only in IDLE. out/out_vld hold stable while out_vld&&!out_rdy.
- Frame start: the first symbol after reset or after done starts from x=M.
- IDLE:
  - On transfer, latch s, f[s], start[s], last.
  - f[s]==0: pulse err next cycle, drop the symbol, x unchanged, remain in IDLE. If last=1, go to FLUSH instead.
  - Otherwise go to RENORM.
- RENORM:
  - If x >= (f[s] << SYM_WIDTH): drive out = x[SYM_WIDTH-1:0], out_vld=1.
  - On transfer: x <= x >> SYM_WIDTH, out_vld<=0, re-evaluate the condition next cycle.
  - Else go to DIVIDE. The check costs 1 cycle when no nibble is needed.
- DIVIDE:
  - Iterative restoring division q = x / f, r = x % f.
  - Exactly STATE_WIDTH cycles.
- UPDATE (1 cycle):
  - x <= q*M + r + start[s], truncated to STATE_WIDTH. No overflow occurs given the parameter constraint.
  - Then: last ? FLUSH : IDLE.
- Latency: with no renormalisation, in_rdy reasserts STATE_WIDTH+2 cycles after the accept edge.
- FLUSH:
  - Emits STATE_WIDTH/SYM_WIDTH nibbles of x, most-significant first, each gated by its own handshake.
  - After the final nibble transfers: pulse done for 1 cycle, x <= M, return to IDLE.
- Invariant after every UPDATE: M <= x < 16*M.
- en low: no state advance, no handshake completes, done/err held at their current values.
- Simultaneous input: in_vld asserted while busy is ignored because in_rdy=0. out_rdy with out_vld=0 has no effect.

Test Plan:
- Example stream (f[0]=8, f[1]=8, others 0; C[0]=8, C[1..15]=16; M=16):
  - Send 1,0,1,1(last) with out_rdy=1.
  - Required out sequence 8,0,0,1,A with x trace 40,80,168,26.
  - done pulses once after A; err never asserts.
- Decoder round-trip: reverse the nibble stream above (A,1,0,0,8) and feed it to ans_decoder with the same tables -> decoded symbols 1,1,0,1.
- Backpressure:
  - Same stream, out_rdy held low for 5 cycles when the renorm nibble 8 is presented -> out=8 stays stable with out_vld=1.
  - in_rdy stays 0 for the whole stall; the final stream is unchanged.
- Zero count: accept symbol 5 (f=0) -> err pulses for 1 cycle, no nibble is emitted, in_rdy=1 on the following cycle, and the x trace is unaffected.
- Latency/en:
  - Accept symbol 1 from x=16 -> in_rdy is high again exactly 18 cycles later.
  - Repeat with en low for 3 cycles mid-DIVIDE -> 21 cycles.
- Reset mid-DIVIDE: assert rst_n low asynchronously -> in_rdy=1 and out_vld=0 immediately. A new frame then reproduces the first scenario's output exactly.
